cam_capture_downsampler: RTL and testbench

- Captures OV7670-style byte-serial camera pixels (CAM_PCLK/HREF/VSYNC/DATA), converts each pixel pair of bytes to RGB332, and generates frame-buffer write address and write-enable for the dual-port M9K frame buffer.
- Parametrised in frame size and address width.
- Adds a selectable conversion mode, including a built-in cross test pattern.
- Sits between the camera GPIO inputs and the M9K write port; the VGA read side is unchanged.

---
 rtl/cam_capture_downsampler.sv | 186 ++++++++++++++++++
 tb/tb_cam_capture_downsampler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_downsampler.sv
// Byte-serial camera capture: synchronise, pair bytes into RGB332 pixels, and generate frame-buffer writes.
// States: IDLE wait first VSYNC | VBLANK wait VSYNC fall | BYTE0 expect first byte | BYTE1 expect second byte.
module cam_capture_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        MODE,
  output logic [7:0]        PIXEL_OUT,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              OVERFLOW
);

  localparam int X_W = $clog2(SCREEN_WIDTH + 1);
  localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [X_W-1:0]    X_MAX    = X_W'(SCREEN_WIDTH);
  localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(SCREEN_HEIGHT);
  localparam logic [X_W-1:0]    X_LO     = X_W'(SCREEN_WIDTH / 2 - 8);
  localparam logic [X_W-1:0]    X_HI     = X_W'(SCREEN_WIDTH / 2 + 8);
  localparam logic [Y_W-1:0]    Y_LO     = Y_W'(SCREEN_HEIGHT / 2 - 8);
  localparam logic [Y_W-1:0]    Y_HI     = Y_W'(SCREEN_HEIGHT / 2 + 8);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_BYTE0, S_BYTE1} state_t;

  state_t            state_q, state_d;
  logic [10:0]       sync1_q, sync2_q;
  logic              pclk_prev_q, href_prev_q, vsync_prev_q;
  logic [X_W-1:0]    x_q, x_d, x_adv;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [7:0]        hi_q, hi_d, lo_q, lo_d;
  logic [1:0]        mode_q, mode_d;
  logic              wr_pend_q;
  logic [7:0]        pixel_q, pixel_d, pix_conv;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              w_en_q, frame_done_q, overflow_q, overflow_d;
  logic              pclk_s, href_s, vsync_s;
  logic [7:0]        data_s;
  logic              se, href_fall, vs_rise, vs_fall, in_range;
  logic              active, frame_start, frame_end, line_end, take_hi, take_lo;

  // PCLK, HREF, VSYNC and DATA share one synchroniser so they stay mutually aligned.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pclk_prev_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      sync1_q      <= {CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_DATA};
      sync2_q      <= sync1_q;
      pclk_prev_q  <= pclk_s;
      href_prev_q  <= href_s;
      vsync_prev_q <= vsync_s;
    end
  end

  assign pclk_s    = sync2_q[10];
  assign href_s    = sync2_q[9];
  assign vsync_s   = sync2_q[8];
  assign data_s    = sync2_q[7:0];
  assign se        = pclk_s & ~pclk_prev_q;
  assign href_fall = href_prev_q & ~href_s;
  assign vs_rise   = vsync_s & ~vsync_prev_q;
  assign vs_fall   = ~vsync_s & vsync_prev_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (vsync_s) state_d = S_VBLANK;
      S_VBLANK: if (vs_fall) state_d = S_BYTE0;
      S_BYTE0, S_BYTE1: begin
        if (vs_rise)             state_d = S_VBLANK;
        else if (href_fall)      state_d = S_BYTE0;
        else if (se && href_s)   state_d = (state_q == S_BYTE0) ? S_BYTE1 : S_BYTE0;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active      = (state_q == S_BYTE0) || (state_q == S_BYTE1);
    frame_start = (state_q == S_VBLANK) && vs_fall;
    frame_end   = active && vs_rise;
    line_end    = active && href_fall && !vs_rise;
    take_hi     = (state_q == S_BYTE0) && se && href_s && !vs_rise;
    take_lo     = (state_q == S_BYTE1) && se && href_s && !vs_rise;
  end

  always_comb begin
    in_range = (x_q < X_MAX) && (y_q < Y_MAX);
    x_adv    = (wr_pend_q && (x_q < X_MAX)) ? x_q + 1'b1 : x_q;
    case (mode_q)
      2'b00:   pix_conv = {hi_q[7:5], hi_q[2:0], lo_q[4:3]};
      2'b01:   pix_conv = {hi_q[6:4], hi_q[1:0], lo_q[7], lo_q[4:3]};
      2'b10:   pix_conv = {hi_q[7:5], hi_q[7:5], hi_q[7:6]};
      default: pix_conv = (((x_q >= X_LO) && (x_q <= X_HI)) || ((y_q >= Y_LO) && (y_q <= Y_HI)))
                          ? 8'hE0 : 8'hFF;
    endcase
  end

  always_comb begin
    hi_d       = take_hi ? data_s : hi_q;
    lo_d       = take_lo ? data_s : lo_q;
    pixel_d    = pixel_q;
    w_addr_d   = w_addr_q;
    x_d        = x_adv;
    y_d        = y_q;
    row_base_d = row_base_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    if (wr_pend_q && in_range) begin
      pixel_d  = pix_conv;
      w_addr_d = row_base_q + ADDR_W'(x_q);
    end
    if (frame_start) begin
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
      overflow_d = 1'b0;
      mode_d     = MODE;
    end else begin
      if (wr_pend_q && !in_range) overflow_d = 1'b1;
      // y and row_base saturate at the frame height so row_base never wraps.
      if (line_end && (x_adv != '0)) begin
        x_d = '0;
        if (y_q < Y_MAX) begin
          y_d        = y_q + 1'b1;
          row_base_d = row_base_q + ROW_STEP;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      x_q          <= '0;
      y_q          <= '0;
      row_base_q   <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mode_q       <= '0;
      wr_pend_q    <= 1'b0;
      pixel_q      <= '0;
      w_addr_q     <= '0;
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      row_base_q   <= row_base_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mode_q       <= mode_d;
      wr_pend_q    <= take_lo;
      pixel_q      <= pixel_d;
      w_addr_q     <= w_addr_d;
      w_en_q       <= wr_pend_q && in_range;
      frame_done_q <= frame_end;
      overflow_q   <= overflow_d;
    end
  end

  assign PIXEL_OUT  = pixel_q;
  assign W_ADDR     = w_addr_q;
  assign W_EN       = w_en_q;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_cam_capture_downsampler.sv
// Directed bench for cam_capture_downsampler on a reduced 32x24 frame with hand-computed pixels.
module tb_cam_capture_downsampler;
  localparam int W  = 32;
  localparam int H  = 24;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, pclk, href, vsync;
  logic [7:0]    data;
  logic [1:0]    mode;
  logic [7:0]    pix;
  logic [AW-1:0] w_addr;
  logic          w_en, frame_done, overflow;

  cam_capture_downsampler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW)) dut (
    .CLK(clk), .RESET_N(rst_n), .CAM_PCLK(pclk), .CAM_HREF(href), .CAM_VSYNC(vsync),
    .CAM_DATA(data), .MODE(mode), .PIXEL_OUT(pix), .W_ADDR(w_addr), .W_EN(w_en),
    .FRAME_DONE(frame_done), .OVERFLOW(overflow)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] log_addr [0:4095];
  logic [7:0]    log_pix  [0:4095];
  int            log_cyc  [0:4095];
  logic [7:0]    mem      [0:1023];
  int            wr_total = 0;
  int            fd_total = 0;

  always @(posedge clk) begin
    #1;
    if (w_en) begin
      if (wr_total < 4096) begin
        log_addr[wr_total] = w_addr;
        log_pix[wr_total]  = pix;
        log_cyc[wr_total]  = cyc;
      end
      mem[w_addr] = pix;
      wr_total++;
    end
    if (frame_done) fd_total++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int rise_cyc;

  task automatic cam_byte(input logic [7:0] b);
    @(negedge clk); data = b; pclk = 1'b0;
    @(negedge clk);
    @(negedge clk); pclk = 1'b1; rise_cyc = cyc;
    @(negedge clk);
    @(negedge clk); pclk = 1'b0;
  endtask

  task automatic href_on();
    @(negedge clk); href = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic href_off();
    repeat (4) @(negedge clk);
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic vs_high();
    @(negedge clk); vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic vs_low();
    @(negedge clk); vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_lines(input int nlines, input int npix, input logic [7:0] b);
    for (int l = 0; l < nlines; l++) begin
      href_on();
      for (int k = 0; k < 2 * npix; k++) cam_byte(b);
      href_off();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int w0, f0, r1, r2, row0;

  initial begin
    rst_n = 1'b0; pclk = 1'b0; href = 1'b0; vsync = 1'b0; data = 8'h00; mode = 2'b00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    check("reset_wen", w_en, 0);
    check("reset_pix", pix, 0);
    check("reset_addr", w_addr, 0);
    check("reset_fd", frame_done, 0);
    check("reset_ovf", overflow, 0);

    // Frame opened from IDLE produces no FRAME_DONE; then reset mid-line.
    f0 = fd_total;
    vs_high();
    vs_low();
    check("idle_no_fd", fd_total - f0, 0);
    w0 = wr_total;
    href_on();
    cam_byte(8'hF8); cam_byte(8'h00); cam_byte(8'h07); cam_byte(8'hE0);
    repeat (6) @(negedge clk);
    check("pre_reset_writes", wr_total - w0, 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midline_rst_wen", w_en, 0);
    check("midline_rst_pix", pix, 0);
    check("midline_rst_addr", w_addr, 0);
    check("midline_rst_ovf", overflow, 0);
    w0 = wr_total;
    cam_byte(8'h12); cam_byte(8'h34); cam_byte(8'h56); cam_byte(8'h78);
    href_off();
    check("post_rst_no_write", wr_total - w0, 0);
    f0 = fd_total;
    vs_high();
    check("post_rst_no_fd", fd_total - f0, 0);
    vs_low();

    // RGB565 line: F8,00 -> E0 at 0; 07,E0 -> 1C at 1; 4 CLK latency each.
    w0 = wr_total;
    href_on();
    cam_byte(8'hF8); cam_byte(8'h00); r1 = rise_cyc;
    cam_byte(8'h07); cam_byte(8'hE0); r2 = rise_cyc;
    href_off();
    check("rgb565_count", wr_total - w0, 2);
    check("rgb565_addr0", log_addr[w0], 0);
    check("rgb565_pix0", log_pix[w0], 8'hE0);
    check("rgb565_lat0", log_cyc[w0] - r1, 4);
    check("rgb565_addr1", log_addr[w0+1], 1);
    check("rgb565_pix1", log_pix[w0+1], 8'h1C);
    check("rgb565_lat1", log_cyc[w0+1] - r2, 4);

    // Empty HREF pulse, odd byte line, mid-frame mode switch.
    href_on(); href_off();
    mode = 2'b10;
    w0 = wr_total;
    href_on();
    cam_byte(8'h11); cam_byte(8'h22); cam_byte(8'h33);
    href_off();
    href_on();
    cam_byte(8'hF8); cam_byte(8'h00);
    href_off();
    check("odd_count", wr_total - w0, 2);
    check("odd_addr", log_addr[w0], W);
    check("odd_pix", log_pix[w0], 8'h04);
    check("next_line_addr", log_addr[w0+1], 2 * W);
    check("mode_hold_pix", log_pix[w0+1], 8'hE0);
    f0 = fd_total;
    vs_high();
    check("fd_pulse", fd_total - f0, 1);
    vs_low();

    // Gray mode now latched: Y=A5 -> {101,101,10}.
    w0 = wr_total;
    href_on();
    cam_byte(8'hA5); cam_byte(8'h00);
    href_off();
    check("gray_addr", log_addr[w0], 0);
    check("gray_pix", log_pix[w0], 8'hB6);

    // RGB555: 52,88 -> {101,10,1,01}.
    mode = 2'b01;
    vs_high();
    vs_low();
    w0 = wr_total;
    href_on();
    cam_byte(8'h52); cam_byte(8'h88);
    href_off();
    check("rgb555_addr", log_addr[w0], 0);
    check("rgb555_pix", log_pix[w0], 8'hB5);

    // Test pattern over a full frame: red band x in [8,24] or y in [4,20].
    mode = 2'b11;
    vs_high();
    vs_low();
    w0 = wr_total;
    frame_lines(H, W, 8'h3C);
    check("tp_count", wr_total - w0, W * H);
    check("tp_last_addr", log_addr[wr_total-1], W * H - 1);
    check("tp_x8", mem[8], 8'hE0);
    check("tp_x7", mem[7], 8'hFF);
    check("tp_x24", mem[24], 8'hE0);
    check("tp_x25", mem[25], 8'hFF);
    check("tp_y4", mem[4*W], 8'hE0);
    check("tp_y3", mem[3*W], 8'hFF);
    check("tp_y20", mem[20*W+31], 8'hE0);
    check("tp_y21", mem[21*W+31], 8'hFF);
    check("tp_ovf", overflow, 0);
    f0 = fd_total;
    vs_high();
    check("tp_fd", fd_total - f0, 1);

    // Oversized frame: 36-pixel lines, 26 lines.
    mode = 2'b00;
    vs_low();
    w0 = wr_total;
    frame_lines(1, W + 4, 8'h00);
    check("ovf_first_line", overflow, 1);
    check("ovf_line0_writes", wr_total - w0, W);
    frame_lines(H + 1, W + 4, 8'h00);
    check("ovf_count", wr_total - w0, W * H);
    check("ovf_last_addr", log_addr[wr_total-1], W * H - 1);
    row0 = 0;
    for (int i = w0; i < wr_total; i++) if (log_addr[i] < W) row0++;
    check("ovf_row0_writes", row0, W);
    check("ovf_sticky", overflow, 1);
    vs_high();
    check("ovf_after_rise", overflow, 1);
    vs_low();
    check("ovf_cleared", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
